// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM-to-stream reader.
package ram_stream_reader_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Output buffer depth; also the ceiling on reads in flight.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// stream_fifo2: two-entry synchronous FIFO that holds returned RAM words
// until the downstream consumer accepts them. The head stays stable while
// the consumer stalls.
module stream_fifo2
  import ram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam logic [FIFO_CNT_W-1:0] CNT_EMPTY = FIFO_CNT_W'(0);
  localparam logic [FIFO_CNT_W-1:0] CNT_FULL  = FIFO_CNT_W'(FIFO_DEPTH);
  localparam logic [FIFO_CNT_W-1:0] CNT_ONE   = FIFO_CNT_W'(1);

  logic [WIDTH-1:0]      mem_r [FIFO_DEPTH];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [FIFO_CNT_W-1:0] cnt_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Qualify push/pop: no pop when empty, push into a full FIFO only alongside a pop.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (pop && (cnt_r != CNT_EMPTY)) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (push && ((cnt_r != CNT_FULL) || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= CNT_EMPTY;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign full  = (cnt_r == CNT_FULL);
  assign empty = (cnt_r == CNT_EMPTY);
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a (base, count) range out of a single-port RAM
// with a one-cycle registered read and re-emits it as a valid/ready stream
// with a last flag. Reads are only issued when a slot is guaranteed in the
// two-entry output buffer, so backpressure never drops or repeats a word.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   count,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] mem_address,
  output logic             mem_oe,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  localparam logic [DEPTH-1:0] ADDR_ZERO = {DEPTH{1'b0}};
  localparam logic [DEPTH-1:0] ADDR_ONE  = {{(DEPTH-1){1'b0}}, 1'b1};
  localparam logic [DEPTH:0]   LEFT_ZERO = {(DEPTH+1){1'b0}};
  localparam logic [DEPTH:0]   LEFT_ONE  = {{DEPTH{1'b0}}, 1'b1};
  localparam logic [1:0]       CREDIT    = 2'(FIFO_DEPTH);

  state_t           state_r;
  logic [DEPTH-1:0] rd_addr_r;
  logic [DEPTH-1:0] addr_hold_r;
  logic [DEPTH:0]   rd_left_r;
  logic [DEPTH:0]   out_left_r;
  logic             pending_r;
  logic             busy_r;
  logic             done_r;

  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [WIDTH-1:0] fifo_head_s;
  logic             pop_s;
  logic             issue_s;
  logic [1:0]       occ_s;
  logic [1:0]       inflight_s;

  // Handshake, credit check and read issue; the address holds between reads.
  always_comb begin
    pop_s       = 1'b0;
    occ_s       = 2'd0;
    inflight_s  = 2'd0;
    issue_s     = 1'b0;
    mem_address = addr_hold_r;
    if (!fifo_empty_s && m_ready) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (fifo_full_s) begin
      occ_s = 2'd2;
    end else if (!fifo_empty_s) begin
      occ_s = 2'd1;
    end else begin
      occ_s = 2'd0;
    end
    // Words already owed to the buffer once this cycle's pop has left it.
    inflight_s = occ_s - {1'b0, pop_s} + {1'b0, pending_r};
    if ((state_r == RUN) && (rd_left_r != LEFT_ZERO) && (inflight_s < CREDIT)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (issue_s) begin
      mem_address = rd_addr_r;
    end else begin
      mem_address = addr_hold_r;
    end
  end

  // Transfer FSM with read/output bookkeeping and registered busy/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      rd_addr_r   <= ADDR_ZERO;
      addr_hold_r <= ADDR_ZERO;
      rd_left_r   <= LEFT_ZERO;
      out_left_r  <= LEFT_ZERO;
      pending_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      pending_r <= issue_s;
      done_r    <= 1'b0;
      if (issue_s) begin
        rd_addr_r   <= rd_addr_r + ADDR_ONE;
        rd_left_r   <= rd_left_r - LEFT_ONE;
        addr_hold_r <= rd_addr_r;
      end
      if (pop_s) begin
        out_left_r <= out_left_r - LEFT_ONE;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r     <= 1'b1;
            rd_addr_r  <= base_addr;
            rd_left_r  <= count;
            out_left_r <= count;
            if (count == LEFT_ZERO) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          if (issue_s && (rd_left_r == LEFT_ONE)) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if ((pop_s && (out_left_r == LEFT_ONE)) || (out_left_r == LEFT_ZERO)) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  stream_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (pending_r),
    .push_data (mem_dout),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s)
  );

  assign mem_oe  = issue_s;
  assign mem_we  = 1'b0;
  assign mem_din = {WIDTH{1'b0}};
  assign m_valid = !fifo_empty_s;
  assign m_data  = fifo_head_s;
  assign m_last  = !fifo_empty_s && (out_left_r == LEFT_ONE);
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural RAM and a
// scoreboard of expected stream words.
module tb_ram_stream_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        busy;
  logic        done;
  logic [9:0]  mem_address;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  ram_stream_reader #(.WIDTH(32), .DEPTH(10)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_oe(mem_oe),
    .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with one-cycle registered read
  logic [31:0] ram [1024];
  initial mem_dout = 32'd0;
  always @(posedge clk) if (mem_oe) mem_dout <= ram[mem_address];

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q [$];
  logic [9:0]  addr_log [$];
  int issued = 0, popped = 0, done_cnt = 0, oe_total = 0, pop_total = 0;
  bit prev_stall = 0;
  logic [31:0] prev_data = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard, stall stability, in-flight bound
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        issued = 0;
        popped = 0;
        prev_stall = 0;
      end else begin
        if (done) done_cnt++;
        if (prev_stall) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, prev_data);
        end
        if (mem_oe) begin
          issued++;
          oe_total++;
          addr_log.push_back(mem_address);
        end
        if (m_valid && m_ready) begin
          popped++;
          pop_total++;
          chk("sb_has_entry", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_data", m_data, e[31:0]);
            chk("sb_last", m_last, e[32]);
          end
        end
        chk("inflight_le2", (issued - popped) <= 2, 1);
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  task automatic start_cmd(input int b, input int n);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 10'(b);
    count = 11'(n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 32'(((b + i) % 1024) + 256)});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag, input bit rnd);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
      if (rnd) m_ready = 1'($urandom_range(0, 1));
    end
    chk(tag, seen, 1);
  endtask

  // base=4 count=3 with m_ready=1: cycle-exact latency/throughput pattern
  task automatic run_timing(input string tag);
    bit         ev [7] = '{0, 0, 1, 1, 1, 0, 0};
    bit         el [7] = '{0, 0, 0, 0, 1, 0, 0};
    bit         ed [7] = '{0, 0, 0, 0, 0, 1, 0};
    bit         eb [7] = '{1, 1, 1, 1, 1, 1, 0};
    bit         eo [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [9:0] ea [7] = '{10'd4, 10'd5, 10'd6, 10'd6, 10'd6, 10'd6, 10'd6};
    m_ready = 1'b1;
    start_cmd(4, 3);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("%s_valid_c%0d", tag, c + 1), m_valid, ev[c]);
      chk($sformatf("%s_last_c%0d", tag, c + 1), m_last, el[c]);
      chk($sformatf("%s_done_c%0d", tag, c + 1), done, ed[c]);
      chk($sformatf("%s_busy_c%0d", tag, c + 1), busy, eb[c]);
      chk($sformatf("%s_oe_c%0d", tag, c + 1), mem_oe, eo[c]);
      chk($sformatf("%s_addr_c%0d", tag, c + 1), mem_address, ea[c]);
    end
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0, p0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'(i + 256);
    reset = 1'b0; start = 1'b0; base_addr = 10'd0; count = 11'd0; m_ready = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_oe", mem_oe, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_din", mem_din, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Basic transfer timing
    run_timing("basic");

    // Zero-length command
    d0 = done_cnt; o0 = oe_total;
    start_cmd(7, 0);
    @(negedge clk);
    chk("zero_done_c1", done, 1);
    chk("zero_busy_c1", busy, 1);
    chk("zero_valid_c1", m_valid, 0);
    @(negedge clk);
    chk("zero_done_c2", done, 0);
    chk("zero_busy_c2", busy, 0);
    repeat (4) @(negedge clk);
    chk("zero_done_once", done_cnt - d0, 1);
    chk("zero_no_oe", oe_total - o0, 0);

    // Address wrap
    addr_log.delete();
    start_cmd(1022, 4);
    wait_done(40, "wrap_done", 0);
    chk("wrap_nreads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("wrap_a0", addr_log[0], 10'd1022);
      chk("wrap_a1", addr_log[1], 10'd1023);
      chk("wrap_a2", addr_log[2], 10'd0);
      chk("wrap_a3", addr_log[3], 10'd1);
    end
    chk("wrap_sb_empty", exp_q.size(), 0);

    // Random backpressure
    p0 = pop_total;
    start_cmd(20, 8);
    wait_done(400, "bp_done", 1);
    m_ready = 1'b1;
    chk("bp_sb_empty", exp_q.size(), 0);
    chk("bp_npop", pop_total - p0, 8);

    // start during RUN is ignored
    p0 = pop_total;
    start_cmd(100, 5);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd300; count = 11'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60, "ign_done", 0);
    repeat (4) @(negedge clk);
    chk("ign_busy", busy, 0);
    chk("ign_sb_empty", exp_q.size(), 0);
    chk("ign_npop", pop_total - p0, 5);

    // Asynchronous reset mid-DRAIN with two words buffered
    m_ready = 1'b0;
    start_cmd(50, 2);
    repeat (4) @(negedge clk);
    chk("drain_valid", m_valid, 1);
    chk("drain_busy", busy, 1);
    chk("drain_head", m_data, 32'h132);
    d0 = done_cnt;
    #1 reset = 1'b0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_last", m_last, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_no_done", done_cnt - d0, 0);
    run_timing("post_rst");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
